fetch_unit: RTL and testbench

Instruction fetch controller sitting directly downstream of the `pc` register and upstream of decode. It reads the current address from `pc`, issues a read to instruction memory with a req/ack handshake, and holds the returned instruction in a valid/ready output register. It drives `pc` back through `pc_next` and `en_pc`, selecting either sequential increment or a branch redirect from execute.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 58 +++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encoding
// and the default address/instruction widths.
package fetch_pkg;

  // Default address width, matching the pc register.
  localparam int FETCH_AW = 8;
  // Default instruction width.
  localparam int FETCH_IW = 16;

  // Fetch sequencing: IDLE after reset, REQ while a memory read is open,
  // HOLD while the instruction register waits for decode.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_unit_if.sv
// Bundle of every signal the fetch unit exchanges with the pc register,
// instruction memory, decode and execute. The fetch unit is the master.
interface fetch_unit_if #(
  parameter int AW = 8,
  parameter int IW = 16
);

  // pc register link
  logic [AW-1:0] pc_in;
  logic [AW-1:0] pc_next;
  logic          en_pc;
  // instruction memory read port
  logic          mem_req;
  logic [AW-1:0] mem_adrs;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;
  // instruction register towards decode
  logic          ir_valid;
  logic [IW-1:0] ir_data;
  logic [AW-1:0] ir_pc;
  logic          ir_ready;
  // redirect from execute
  logic          br_taken;
  logic [AW-1:0] br_target;

  modport master (
    input  pc_in,
    output pc_next,
    output en_pc,
    output mem_req,
    output mem_adrs,
    input  mem_ack,
    input  mem_rdata,
    output ir_valid,
    output ir_data,
    output ir_pc,
    input  ir_ready,
    input  br_taken,
    input  br_target
  );

  modport slave (
    output pc_in,
    input  pc_next,
    input  en_pc,
    input  mem_req,
    input  mem_adrs,
    output mem_ack,
    output mem_rdata,
    input  ir_valid,
    input  ir_data,
    input  ir_pc,
    output ir_ready,
    output br_taken,
    output br_target
  );

endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// Instruction fetch controller. Reads the current PC, performs a req/ack read
// of instruction memory, holds the result in a valid/ready instruction
// register and steers the pc register with either PC+1 or a branch target.
// A redirect that arrives while a read is still open is parked in a pending
// latch and applied when that read completes, its data being discarded.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_AW,
  parameter int IW = FETCH_IW
) (
  input logic          clk,
  input logic          clr,
  fetch_unit_if.master bus
);

  fetch_state_t  state_r;
  logic          pend_v_r;
  logic [AW-1:0] pend_tgt_r;
  logic          mem_req_r;
  logic          ir_valid_r;
  logic [IW-1:0] ir_data_r;
  logic [AW-1:0] ir_pc_r;

  logic          en_pc_s;
  logic [AW-1:0] pc_next_s;
  logic [AW-1:0] pc_inc_s;

  // Sequential successor; the natural AW-bit overflow gives the wrap to zero.
  assign pc_inc_s = bus.pc_in + {{(AW-1){1'b0}}, 1'b1};

  // Next-PC steering: execute redirect beats a parked redirect, which beats
  // the sequential increment. Without a load strobe pc_next mirrors pc_in.
  always_comb begin
    en_pc_s   = 1'b0;
    pc_next_s = bus.pc_in;
    case (state_r)
      IDLE: begin
        if (bus.br_taken) begin
          en_pc_s   = 1'b1;
          pc_next_s = bus.br_target;
        end else begin
          en_pc_s   = 1'b0;
          pc_next_s = bus.pc_in;
        end
      end
      REQ: begin
        // The PC only moves at ack time so the read address stays stable.
        if (bus.mem_ack) begin
          en_pc_s = 1'b1;
          if (bus.br_taken) begin
            pc_next_s = bus.br_target;
          end else if (pend_v_r) begin
            pc_next_s = pend_tgt_r;
          end else begin
            pc_next_s = pc_inc_s;
          end
        end else begin
          en_pc_s   = 1'b0;
          pc_next_s = bus.pc_in;
        end
      end
      HOLD: begin
        if (bus.br_taken) begin
          en_pc_s   = 1'b1;
          pc_next_s = bus.br_target;
        end else begin
          en_pc_s   = 1'b0;
          pc_next_s = bus.pc_in;
        end
      end
      default: begin
        en_pc_s   = 1'b0;
        pc_next_s = bus.pc_in;
      end
    endcase
  end

  // Fetch FSM with its registered outputs and the pending-redirect latch.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r    <= IDLE;
      pend_v_r   <= 1'b0;
      pend_tgt_r <= {AW{1'b0}};
      mem_req_r  <= 1'b0;
      ir_valid_r <= 1'b0;
      ir_data_r  <= {IW{1'b0}};
      ir_pc_r    <= {AW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // One quiet cycle so the pc register is out of reset before reading.
          state_r   <= REQ;
          mem_req_r <= 1'b1;
        end
        REQ: begin
          if (bus.mem_ack) begin
            pend_v_r <= 1'b0;
            if (bus.br_taken || pend_v_r) begin
              // Data belongs to the abandoned path; restart at the target.
              state_r   <= REQ;
              mem_req_r <= 1'b1;
            end else begin
              ir_data_r  <= bus.mem_rdata;
              ir_pc_r    <= bus.pc_in;
              ir_valid_r <= 1'b1;
              mem_req_r  <= 1'b0;
              state_r    <= HOLD;
            end
          end else if (bus.br_taken) begin
            pend_v_r   <= 1'b1;
            pend_tgt_r <= bus.br_target;
          end else begin
            pend_v_r   <= pend_v_r;
            pend_tgt_r <= pend_tgt_r;
          end
        end
        HOLD: begin
          // Either decode takes the instruction or a redirect kills it;
          // both reopen a read at whatever pc now holds.
          if (bus.ir_ready || bus.br_taken) begin
            ir_valid_r <= 1'b0;
            mem_req_r  <= 1'b1;
            state_r    <= REQ;
          end else begin
            ir_valid_r <= 1'b1;
            mem_req_r  <= 1'b0;
            state_r    <= HOLD;
          end
        end
        default: begin
          state_r    <= IDLE;
          pend_v_r   <= 1'b0;
          mem_req_r  <= 1'b0;
          ir_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.en_pc    = en_pc_s;
  assign bus.pc_next  = pc_next_s;
  assign bus.mem_req  = mem_req_r;
  assign bus.mem_adrs = bus.pc_in;
  assign bus.ir_valid = ir_valid_r;
  assign bus.ir_data  = ir_data_r;
  assign bus.ir_pc    = ir_pc_r;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed cycle table, a reset
// sequence with a late ack, and a randomized run against a transaction-level
// reference model. The pc register is modelled here as a plain loadable reg.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk;
  logic clr;
  logic [7:0] pc_r;

  int checks;
  int failures;

  fetch_unit_if #(.AW(8), .IW(16)) bus ();

  fetch_unit #(.AW(8), .IW(16)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // pc register that fetch_unit steers through pc_next/en_pc.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) pc_r <= 8'h00;
    else if (bus.en_pc) pc_r <= bus.pc_next;
  end
  assign bus.pc_in = pc_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a function of address.
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'hC3, a};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ack;
    logic [15:0] rdata;
    logic        rdy;
    logic        br;
    logic [7:0]  tgt;
    logic        req;
    logic [7:0]  adrs;
    logic        en;
    logic [7:0]  nxt;
    logic        irv;
    logic [7:0]  irpc;
    logic [15:0] ird;
  } vec_t;

  function automatic vec_t mk(logic ack, logic [15:0] rdata, logic rdy, logic br,
                              logic [7:0] tgt, logic req, logic [7:0] adrs, logic en,
                              logic [7:0] nxt, logic irv, logic [7:0] irpc, logic [15:0] ird);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.req = req; v.adrs = adrs; v.en = en; v.nxt = nxt;
    v.irv = irv; v.irpc = irpc; v.ird = ird;
    return v;
  endfunction

  task automatic drive(input logic ack, input logic [15:0] rdata, input logic rdy,
                       input logic br, input logic [7:0] tgt);
    bus.mem_ack   = ack;
    bus.mem_rdata = rdata;
    bus.ir_ready  = rdy;
    bus.br_taken  = br;
    bus.br_target = tgt;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mem_req"},  {15'd0, bus.mem_req},  16'd0);
    chk({tag, "_en_pc"},    {15'd0, bus.en_pc},    16'd0);
    chk({tag, "_pc_next"},  {8'd0, bus.pc_next},   16'd0);
    chk({tag, "_ir_valid"}, {15'd0, bus.ir_valid}, 16'd0);
    chk({tag, "_ir_data"},  bus.ir_data,           16'd0);
    chk({tag, "_ir_pc"},    {8'd0, bus.ir_pc},     16'd0);
  endtask

  vec_t tbl[26];

  // Transaction-level reference state for the randomized run.
  logic [7:0] m_addr;
  bit         m_redir_v;
  logic [7:0] m_redir_t;
  logic [7:0] held_q[$];
  int         delivered;

  initial begin
    checks = 0;
    failures = 0;
    delivered = 0;

    // cycle by cycle from the first IDLE cycle after reset
    //            ack  rdata     rdy   br    tgt    req   adrs   en    nxt    irv   irpc   ird
    tbl[0]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
    tbl[1]  = mk(1'b1, 16'hA000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0000);
    tbl[2]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 8'h01, 1'b1, 8'h00, 16'hA000);
    tbl[3]  = mk(1'b1, 16'hA001, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'h00, 16'hA000);
    tbl[4]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 8'h02, 1'b1, 8'h01, 16'hA001);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = tbl[4];
    tbl[8]  = tbl[4];
    tbl[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 8'h02, 1'b1, 8'h01, 16'hA001);
    tbl[10] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 8'h40, 1'b1, 8'h02, 1'b0, 8'h02, 1'b0, 8'h01, 16'hA001);
    tbl[11] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h02, 1'b0, 8'h01, 16'hA001);
    tbl[12] = tbl[11];
    tbl[13] = mk(1'b1, 16'hBEEF, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h40, 1'b0, 8'h01, 16'hA001);
    tbl[14] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h40, 1'b0, 8'h01, 16'hA001);
    tbl[15] = mk(1'b1, 16'hA040, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 8'h41, 1'b0, 8'h01, 16'hA001);
    tbl[16] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h41, 1'b1, 8'hFF, 1'b1, 8'h40, 16'hA040);
    tbl[17] = mk(1'b1, 16'hA0FF, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h40, 16'hA040);
    tbl[18] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 16'hA0FF);
    tbl[19] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 8'h20, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFF, 16'hA0FF);
    tbl[20] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 8'h30, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFF, 16'hA0FF);
    tbl[21] = mk(1'b1, 16'hDEAD, 1'b0, 1'b1, 8'h30, 1'b1, 8'h00, 1'b1, 8'h30, 1'b0, 8'hFF, 16'hA0FF);
    tbl[22] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 8'h30, 1'b0, 8'hFF, 16'hA0FF);
    tbl[23] = mk(1'b1, 16'hA030, 1'b0, 1'b0, 8'h00, 1'b1, 8'h30, 1'b1, 8'h31, 1'b0, 8'hFF, 16'hA0FF);
    tbl[24] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 8'h10, 1'b0, 8'h31, 1'b1, 8'h10, 1'b1, 8'h30, 16'hA030);
    tbl[25] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 8'h10, 1'b0, 8'h30, 16'hA030);

    // Reset state.
    clr = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("rst");
    @(posedge clk);
    #2 clr = 1'b0;

    // Directed table: sequential fetch, back-pressure, redirects, wrap.
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
      #1;
      chk($sformatf("tbl%0d_mem_req", i),  {15'd0, bus.mem_req},  {15'd0, tbl[i].req});
      chk($sformatf("tbl%0d_mem_adrs", i), {8'd0, bus.mem_adrs},  {8'd0, tbl[i].adrs});
      chk($sformatf("tbl%0d_en_pc", i),    {15'd0, bus.en_pc},    {15'd0, tbl[i].en});
      chk($sformatf("tbl%0d_pc_next", i),  {8'd0, bus.pc_next},   {8'd0, tbl[i].nxt});
      chk($sformatf("tbl%0d_ir_valid", i), {15'd0, bus.ir_valid}, {15'd0, tbl[i].irv});
      chk($sformatf("tbl%0d_ir_pc", i),    {8'd0, bus.ir_pc},     {8'd0, tbl[i].irpc});
      chk($sformatf("tbl%0d_ir_data", i),  bus.ir_data,           tbl[i].ird);
    end

    // Reset in the middle of an open request (REQ at 0x10), no clock edge.
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    clr = 1'b1;
    #1;
    chk_reset_values("midreq_rst");
    @(posedge clk);
    #2 clr = 1'b0;
    // Late ack during IDLE must be ignored.
    @(negedge clk);
    drive(1'b1, 16'h1234, 1'b0, 1'b0, 8'h00);
    #1;
    chk("late_ack_en_pc",   {15'd0, bus.en_pc},    16'd0);
    chk("late_ack_mem_req", {15'd0, bus.mem_req},  16'd0);
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    #1;
    chk("restart_mem_req",  {15'd0, bus.mem_req},  16'd1);
    chk("restart_mem_adrs", {8'd0, bus.mem_adrs},  16'h0000);
    chk("restart_ir_valid", {15'd0, bus.ir_valid}, 16'd0);
    @(negedge clk);
    drive(1'b1, mem_word(8'h00), 1'b0, 1'b0, 8'h00);
    #1;
    chk("restart_pc_next",  {8'd0, bus.pc_next},   16'h0001);
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    #1;
    chk("restart_ir_valid1", {15'd0, bus.ir_valid}, 16'd1);
    chk("restart_ir_pc",     {8'd0, bus.ir_pc},     16'h0000);
    chk("restart_ir_data",   bus.ir_data,           mem_word(8'h00));

    // Randomized run from a fresh reset, starting with a redirect in IDLE.
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    m_redir_t = 8'($urandom());
    drive(1'b0, 16'h0000, 1'b0, 1'b1, m_redir_t);
    #1;
    chk("idle_br_en_pc",   {15'd0, bus.en_pc},  16'd1);
    chk("idle_br_pc_next", {8'd0, bus.pc_next}, {8'd0, m_redir_t});
    chk("idle_br_mem_req", {15'd0, bus.mem_req}, 16'd0);
    m_addr = m_redir_t;
    m_redir_v = 1'b0;
    held_q.delete();

    for (int c = 0; c < 2000; c++) begin
      bit         holding;
      logic       ack;
      logic       rdy;
      logic       br;
      logic [7:0] tgt;
      logic [7:0] exp_nxt;
      @(negedge clk);
      holding = (held_q.size() != 0);
      ack = !holding && ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      br  = ($urandom_range(0, 7) == 0);
      tgt = 8'($urandom());
      drive(ack, ack ? mem_word(bus.mem_adrs) : 16'h0000, rdy, br, tgt);
      #1;
      if (!holding) begin
        if (!ack) exp_nxt = m_addr;
        else if (br) exp_nxt = tgt;
        else if (m_redir_v) exp_nxt = m_redir_t;
        else exp_nxt = 8'(m_addr + 8'd1);
        chk("rnd_req_mem_req",  {15'd0, bus.mem_req},  16'd1);
        chk("rnd_req_mem_adrs", {8'd0, bus.mem_adrs},  {8'd0, m_addr});
        chk("rnd_req_ir_valid", {15'd0, bus.ir_valid}, 16'd0);
        chk("rnd_req_en_pc",    {15'd0, bus.en_pc},    {15'd0, ack});
        chk("rnd_req_pc_next",  {8'd0, bus.pc_next},   {8'd0, exp_nxt});
      end else begin
        chk("rnd_hold_mem_req",  {15'd0, bus.mem_req},  16'd0);
        chk("rnd_hold_ir_valid", {15'd0, bus.ir_valid}, 16'd1);
        chk("rnd_hold_ir_pc",    {8'd0, bus.ir_pc},     {8'd0, held_q[0]});
        chk("rnd_hold_ir_data",  bus.ir_data,           mem_word(held_q[0]));
        chk("rnd_hold_en_pc",    {15'd0, bus.en_pc},    {15'd0, br});
        chk("rnd_hold_pc_next",  {8'd0, bus.pc_next},   {8'd0, (br ? tgt : m_addr)});
      end
      // Advance the model across the coming clock edge.
      if (!holding) begin
        if (ack) begin
          if (br) m_addr = tgt;
          else if (m_redir_v) m_addr = m_redir_t;
          else begin
            held_q.push_back(m_addr);
            m_addr = 8'(m_addr + 8'd1);
          end
          m_redir_v = 1'b0;
        end else if (br) begin
          m_redir_v = 1'b1;
          m_redir_t = tgt;
        end
      end else if (rdy || br) begin
        void'(held_q.pop_front());
        if (rdy) delivered++;
        if (br) m_addr = tgt;
      end
    end
    chk("rnd_progress", {15'd0, (delivered > 50)}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_unit
